// File: rtl/tone_drive_sequencer.sv
// -----------------------------------------------------------------------------
// tone_drive_sequencer
//   Turns the 3-bit toneDir code from the tone detection stage into timed
//   H-bridge commands. A code must stay stable before it is accepted. Both
//   motors are then driven with PWM for DRIVE_CYCLES. After that the motors
//   coast (all outputs off) for COAST_CYCLES before a new code is accepted.
//
//   Code map: 1 = forward, 2 = reverse, 3 = left (L rev, R fwd),
//             4 = right (L fwd, R rev); 0 and 5..7 mean no command.
//
//   Optional build macro DRIVE_RAMP_EN: soft start. The duty starts at 0 on
//   DRIVE entry and rises by RAMP_STEP at every PWM period boundary, clamped
//   to PWM_DUTY. Without the macro the duty is PWM_DUTY from the first DRIVE
//   cycle, and no ramp logic is built.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous reset, active-low
//   enableDrive  in   1 = commands may be accepted, 0 = abort to IDLE
//   toneDir      in   [2:0] direction code from tone detection
//   motorL_pwm   out  left motor PWM
//   motorR_pwm   out  right motor PWM
//   motorL_dir   out  left motor direction (1 = forward)
//   motorR_dir   out  right motor direction (1 = forward)
//   busy         out  high in QUALIFY, DRIVE and COAST
//   cmdDone      out  one-cycle pulse as DRIVE hands over to COAST
// -----------------------------------------------------------------------------
module tone_drive_sequencer #(
  parameter int QUAL_CYCLES  = 250000,
  parameter int DRIVE_CYCLES = 25000000,
  parameter int COAST_CYCLES = 2500000,
  parameter int PWM_PERIOD   = 1000,
  parameter int PWM_DUTY     = 600,
  parameter int RAMP_STEP    = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enableDrive,
  input  logic [2:0] toneDir,
  output logic       motorL_pwm,
  output logic       motorR_pwm,
  output logic       motorL_dir,
  output logic       motorR_dir,
  output logic       busy,
  output logic       cmdDone
);

  localparam int QW  = $clog2(QUAL_CYCLES  > 2 ? QUAL_CYCLES  : 2);
  localparam int DW  = $clog2(DRIVE_CYCLES > 2 ? DRIVE_CYCLES : 2);
  localparam int CW  = $clog2(COAST_CYCLES > 2 ? COAST_CYCLES : 2);
  localparam int PW  = $clog2(PWM_PERIOD   > 2 ? PWM_PERIOD   : 2);
  localparam int DUW = $clog2(PWM_PERIOD + 1);

  localparam logic [QW-1:0] QUAL_LAST  = QW'(QUAL_CYCLES - 1);
  localparam logic [DW-1:0] DRIVE_LAST = DW'(DRIVE_CYCLES - 1);
  localparam logic [CW-1:0] COAST_LAST = CW'(COAST_CYCLES - 1);
  localparam logic [PW-1:0] PWM_LAST   = PW'(PWM_PERIOD - 1);

  if (PWM_DUTY < 0 || PWM_DUTY > PWM_PERIOD || RAMP_STEP < 0) begin : g_bad_param
    $error("tone_drive_sequencer: PWM_DUTY must lie in 0..PWM_PERIOD and RAMP_STEP must be >= 0");
  end

  typedef enum logic [1:0] {S_IDLE, S_QUALIFY, S_DRIVE, S_COAST} state_t;

  state_t          state_q;
  logic [2:0]      cand_q;
  logic [2:0]      cmd_q;
  logic [QW-1:0]   qual_q;
  logic [DW-1:0]   drive_q;
  logic [CW-1:0]   coast_q;
  logic [PW-1:0]   pwmCnt_q;
  logic [PW-1:0]   pwmCnt_d;
  logic            pwm_d;
  logic            pwmFirst;

  function automatic logic code_valid(input logic [2:0] code);
    return (code >= 3'd1) && (code <= 3'd4);
  endfunction

  // {left_dir, right_dir} for a code; "none" codes give both reverse (0).
  function automatic logic [1:0] code_dirs(input logic [2:0] code);
    case (code)
      3'd1:    return 2'b11;
      3'd3:    return 2'b01;
      3'd4:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

`ifdef DRIVE_RAMP_EN
  logic [DUW-1:0] duty_q;
  logic [DUW-1:0] duty_d;

  function automatic logic [DUW-1:0] ramp_clamp(input logic [DUW-1:0] d);
    int s;
    s = int'(d) + RAMP_STEP;
    if (s > PWM_DUTY) s = PWM_DUTY;
    return DUW'(s);
  endfunction

  // Duty steps up only when the PWM counter wraps to a new period.
  always_comb begin
    pwmCnt_d = (pwmCnt_q == PWM_LAST) ? '0 : pwmCnt_q + 1'b1;
    duty_d   = (pwmCnt_q == PWM_LAST) ? ramp_clamp(duty_q) : duty_q;
    pwm_d    = int'(pwmCnt_d) < int'(duty_d);
    pwmFirst = 1'b0;
  end
`else
  always_comb begin
    pwmCnt_d = (pwmCnt_q == PWM_LAST) ? '0 : pwmCnt_q + 1'b1;
    pwm_d    = int'(pwmCnt_d) < PWM_DUTY;
    pwmFirst = (PWM_DUTY > 0);
  end
`endif

  // Outputs are registered from the next-state decision, so they line up
  // with the state they describe (first DRIVE cycle already shows pwm/dir).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cand_q     <= '0;
      cmd_q      <= '0;
      qual_q     <= '0;
      drive_q    <= '0;
      coast_q    <= '0;
      pwmCnt_q   <= '0;
      motorL_pwm <= 1'b0;
      motorR_pwm <= 1'b0;
      motorL_dir <= 1'b0;
      motorR_dir <= 1'b0;
      busy       <= 1'b0;
      cmdDone    <= 1'b0;
`ifdef DRIVE_RAMP_EN
      duty_q     <= '0;
`endif
    end else if (!enableDrive) begin
      state_q    <= S_IDLE;
      qual_q     <= '0;
      drive_q    <= '0;
      coast_q    <= '0;
      pwmCnt_q   <= '0;
      motorL_pwm <= 1'b0;
      motorR_pwm <= 1'b0;
      motorL_dir <= 1'b0;
      motorR_dir <= 1'b0;
      busy       <= 1'b0;
      cmdDone    <= 1'b0;
`ifdef DRIVE_RAMP_EN
      duty_q     <= '0;
`endif
    end else begin
      cmdDone <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (code_valid(toneDir)) begin
            cand_q  <= toneDir;
            qual_q  <= '0;
            state_q <= S_QUALIFY;
            busy    <= 1'b1;
          end
        end
        S_QUALIFY: begin
          if (toneDir == cand_q) begin
            if (qual_q == QUAL_LAST) begin
              cmd_q      <= cand_q;
              state_q    <= S_DRIVE;
              drive_q    <= '0;
              pwmCnt_q   <= '0;
              motorL_pwm <= pwmFirst;
              motorR_pwm <= pwmFirst;
              {motorL_dir, motorR_dir} <= code_dirs(cand_q);
`ifdef DRIVE_RAMP_EN
              duty_q     <= '0;
`endif
            end else begin
              qual_q <= qual_q + 1'b1;
            end
          end else if (code_valid(toneDir)) begin
            cand_q <= toneDir;
            qual_q <= '0;
          end else begin
            state_q <= S_IDLE;
            qual_q  <= '0;
            busy    <= 1'b0;
          end
        end
        S_DRIVE: begin
          // toneDir is deliberately not looked at here: no command queueing.
          if (drive_q == DRIVE_LAST) begin
            state_q    <= S_COAST;
            drive_q    <= '0;
            coast_q    <= '0;
            pwmCnt_q   <= '0;
            motorL_pwm <= 1'b0;
            motorR_pwm <= 1'b0;
            motorL_dir <= 1'b0;
            motorR_dir <= 1'b0;
            cmdDone    <= 1'b1;
`ifdef DRIVE_RAMP_EN
            duty_q     <= '0;
`endif
          end else begin
            drive_q    <= drive_q + 1'b1;
            pwmCnt_q   <= pwmCnt_d;
            motorL_pwm <= pwm_d;
            motorR_pwm <= pwm_d;
            {motorL_dir, motorR_dir} <= code_dirs(cmd_q);
`ifdef DRIVE_RAMP_EN
            duty_q     <= duty_d;
`endif
          end
        end
        S_COAST: begin
          if (coast_q == COAST_LAST) begin
            state_q <= S_IDLE;
            coast_q <= '0;
            busy    <= 1'b0;
          end else begin
            coast_q <= coast_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_drive_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tone_drive_sequencer
//   Directed bench for tone_drive_sequencer with QUAL=4, DRIVE=20, COAST=3,
//   PERIOD=5, DUTY=3, RAMP_STEP=1. The outputs are packed as
//   {L_pwm, R_pwm, L_dir, R_dir, busy, cmdDone}.
// -----------------------------------------------------------------------------
module tb_tone_drive_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enableDrive;
  logic [2:0] toneDir;
  logic       motorL_pwm, motorR_pwm, motorL_dir, motorR_dir, busy, cmdDone;
  logic [5:0] outs;

  int errors = 0;
  int checks = 0;

  tone_drive_sequencer #(
    .QUAL_CYCLES (4),
    .DRIVE_CYCLES(20),
    .COAST_CYCLES(3),
    .PWM_PERIOD  (5),
    .PWM_DUTY    (3),
    .RAMP_STEP   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enableDrive(enableDrive),
    .toneDir    (toneDir),
    .motorL_pwm (motorL_pwm),
    .motorR_pwm (motorR_pwm),
    .motorL_dir (motorL_dir),
    .motorR_dir (motorR_dir),
    .busy       (busy),
    .cmdDone    (cmdDone)
  );

  assign outs = {motorL_pwm, motorR_pwm, motorL_dir, motorR_dir, busy, cmdDone};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // High cycles in PWM period p of a drive (4 periods of 5 cycles).
  function automatic int exp_high(input int p);
`ifdef DRIVE_RAMP_EN
    int tbl [4] = '{0, 1, 2, 3};
`else
    int tbl [4] = '{3, 3, 3, 3};
`endif
    return tbl[p];
  endfunction

  // Expected pwm at drive cycle k: high in the first duty cycles of a period.
  function automatic logic exp_pwm(input int k);
    return (k % 5) < exp_high(k / 5);
  endfunction

  // Starting from IDLE (or mid-QUALIFY with another code), present code and
  // follow it through qualify, drive, coast and back to idle.
  task automatic drive_seq(input logic [2:0] code, input logic l, input logic r);
    int  hi;
    logic p;
    hi = 0;
    toneDir = code;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("qualify", outs, 6'b000010);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      p = exp_pwm(k);
      chk("drive", outs, {p, p, l, r, 1'b1, 1'b0});
      if (motorL_pwm === 1'b1) hi++;
      if ((k % 5) == 4) begin
        chk_int("duty_per_period", hi, exp_high(k / 5));
        hi = 0;
      end
    end
    tick();
    chk("cmd_done", outs, 6'b000011);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("coast", outs, 6'b000010);
    end
    tick();
    chk("back_idle", outs, 6'b000000);
  endtask

  initial begin
    rst         = 1'b0;
    enableDrive = 1'b1;
    toneDir     = 3'd1;

    // Reset held with a valid code present.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("reset", outs, 6'b000000);
    end
    rst = 1'b1;

    // Forward command right after reset release.
    drive_seq(3'd1, 1'b1, 1'b1);

    // Code still present at the end of COAST: picked up on the next IDLE cycle.
    tick();
    chk("recapture_after_coast", outs, 6'b000010);
    enableDrive = 1'b0;
    toneDir     = 3'd0;
    tick();
    chk("abort_qualify", outs, 6'b000000);
    enableDrive = 1'b1;

    // Left for two cycles, then right held: must requalify on right.
    toneDir = 3'd3;
    tick();
    chk("left_capture", outs, 6'b000010);
    tick();
    chk("left_qualify", outs, 6'b000010);
    drive_seq(3'd4, 1'b1, 1'b0);

    // Reverse and left as full commands.
    toneDir = 3'd0;
    tick();
    chk("idle_gap", outs, 6'b000000);
    drive_seq(3'd2, 1'b0, 1'b0);
    toneDir = 3'd0;
    tick();
    chk("idle_gap", outs, 6'b000000);
    drive_seq(3'd3, 1'b0, 1'b1);

    // "None" codes never leave IDLE.
    begin
      logic [2:0] none_codes [4] = '{3'd6, 3'd0, 3'd5, 3'd7};
      for (int i = 0; i < 4; i++) begin
        toneDir = none_codes[i];
        for (int c = 0; c < 3; c++) begin
          tick();
          chk("none_code_idle", outs, 6'b000000);
        end
      end
    end

    // Abort at DRIVE cycle 7; a toneDir change mid-DRIVE is ignored.
    toneDir = 3'd1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("abort_qualify_phase", outs, 6'b000010);
    end
    for (int k = 0; k < 8; k++) begin
      logic p;
      tick();
      p = exp_pwm(k);
      chk("abort_drive", outs, {p, p, 1'b1, 1'b1, 1'b1, 1'b0});
      if (k == 3) toneDir = 3'd2;
    end
    enableDrive = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("aborted", outs, 6'b000000);
    end
    enableDrive = 1'b1;
    toneDir     = 3'd0;
    tick();
    chk("post_abort_idle", outs, 6'b000000);

    // Reset in the middle of DRIVE.
    toneDir = 3'd4;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rst_qualify_phase", outs, 6'b000010);
    end
    for (int k = 0; k < 3; k++) begin
      logic p;
      tick();
      p = exp_pwm(k);
      chk("rst_drive", outs, {p, p, 1'b1, 1'b0, 1'b1, 1'b0});
    end
    rst = 1'b0;
    tick();
    chk("mid_reset", outs, 6'b000000);
    rst     = 1'b1;
    toneDir = 3'd0;
    tick();
    chk("post_reset_idle", outs, 6'b000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
